// File: rtl/mul_add_pkg.sv
// mul_add_pkg -- shared types and constants for the mul_add_pipe datapath.
//
//   STAGES : number of registered datapath stages (S0, S1, S2).
//   MAX_W  : widest legal operand width; stage-0 fields are sized to it so the
//            struct can serve every WIDTH. Users keep only the low WIDTH bits.
//   s0_t   : stage-0 capture (x, y, z, acc_mode).
package mul_add_pkg;

    localparam int STAGES = 3;
    localparam int MAX_W  = 64;

    typedef struct packed {
        logic [MAX_W-1:0] x;
        logic [MAX_W-1:0] y;
        logic [MAX_W-1:0] z;
        logic             acc_mode;
    } s0_t;

endpackage

// File: rtl/mul_add_mul_stage.sv
// mul_add_mul_stage -- product stage: multiplies the S0 operands and registers
// the product, addend and mode into S1. Valid tracking lives in the parent.
//
// Configuration macro: MUL_ADD_PIPE_SAT_EN (product saturates to all-ones on
// overflow instead of wrapping modulo 2^WIDTH).
//
// Ports:
//   clk_i         : clock, rising edge
//   ld_p1_i       : load enable for the S1 registers
//   data_p0_i     : S0 contents (x, y, z, acc_mode), zero-extended to MAX_W
//   prod_p1_o     : S1 product
//   z_p1_o        : S1 addend z
//   acc_mode_p1_o : S1 accumulate-mode flag
module mul_add_mul_stage
    import mul_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             ld_p1_i,
    input  s0_t              data_p0_i,
    output logic [WIDTH-1:0] prod_p1_o,
    output logic [WIDTH-1:0] z_p1_o,
    output logic             acc_mode_p1_o
);

    function automatic logic [WIDTH-1:0] mul_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
`ifdef MUL_ADD_PIPE_SAT_EN
        logic [2*WIDTH-1:0] full;
        full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        return (|full[2*WIDTH-1:WIDTH]) ? '1 : full[WIDTH-1:0];
`else
        return a * b;
`endif
    endfunction

    logic [WIDTH-1:0] x_p0;
    logic [WIDTH-1:0] y_p0;
    logic [WIDTH-1:0] z_p0;
    logic             unused_hi;

    logic [WIDTH-1:0] prod_p1_q;
    logic [WIDTH-1:0] z_p1_q;
    logic             acc_mode_p1_q;

    assign x_p0 = data_p0_i.x[WIDTH-1:0];
    assign y_p0 = data_p0_i.y[WIDTH-1:0];
    assign z_p0 = data_p0_i.z[WIDTH-1:0];

    // Bits above WIDTH are always zero; fold them away.
    assign unused_hi = ^{data_p0_i.x, data_p0_i.y, data_p0_i.z};

    // ---- S0 -> S1 boundary ----
    always_ff @(posedge clk_i) begin
        if (ld_p1_i) begin
            prod_p1_q     <= mul_fn(x_p0, y_p0);
            z_p1_q        <= z_p0;
            acc_mode_p1_q <= data_p0_i.acc_mode;
        end
    end

    assign prod_p1_o     = prod_p1_q;
    assign z_p1_o        = z_p1_q;
    assign acc_mode_p1_o = acc_mode_p1_q;

endmodule

// File: rtl/mul_add_pipe.sv
// mul_add_pipe -- three-stage pipelined multiply-add with valid/ready
// handshakes and a running accumulator.
//   out = x*y + (acc_mode ? acc : z); acc follows every result.
//
// Configuration macro: MUL_ADD_PIPE_SAT_EN (product and sum saturate to
// all-ones instead of wrapping modulo 2^WIDTH; acc keeps the saturated value).
//
// Parameters: WIDTH (8..64), ACC_INIT (accumulator value after reset).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : x/y/z/acc_mode valid       in_ready  : input accepted
//   x, y      : unsigned operands          z         : addend when acc_mode=0
//   acc_mode  : add product to acc
//   out_valid : out holds a result         out_ready : downstream accepts
//   out       : result, zero while out_valid=0
module mul_add_pipe
    import mul_add_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    function automatic logic [WIDTH-1:0] add_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
`ifdef MUL_ADD_PIPE_SAT_EN
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    logic             run_q;
    logic             vld_p0_q, vld_p1_q, vld_p2_q;
    logic             vld_p0_d, vld_p1_d, vld_p2_d;
    logic             ld_p0, ld_p1, ld_p2;

    s0_t              data_p0_q, data_p0_d;
    logic [WIDTH-1:0] prod_p1, z_p1;
    logic             acc_mode_p1;
    logic [WIDTH-1:0] res_p2_q, res_p2_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] addend_p1;

    // Each stage loads when empty or when its occupant moves on this cycle,
    // so readiness ripples back from out_ready without a bubble. run_q holds
    // in_ready low during reset without using rst_n as logic.
    always_comb begin
        ld_p2    = vld_p1_q && (!vld_p2_q || out_ready);
        ld_p1    = vld_p0_q && (!vld_p1_q || ld_p2);
        in_ready = run_q && (!vld_p0_q || ld_p1);
        ld_p0    = in_valid && in_ready;
        vld_p0_d = ld_p0 || (vld_p0_q && !ld_p1);
        vld_p1_d = ld_p1 || (vld_p1_q && !ld_p2);
        vld_p2_d = ld_p2 || (vld_p2_q && !out_ready);
    end

    always_comb begin
        data_p0_d          = '0;
        data_p0_d.x        = MAX_W'(x);
        data_p0_d.y        = MAX_W'(y);
        data_p0_d.z        = MAX_W'(z);
        data_p0_d.acc_mode = acc_mode;
    end

    // acc is read here at the S1->S2 transfer, so consecutive accumulate
    // items see each other's results without forwarding.
    assign addend_p1 = acc_mode_p1 ? acc_q : z_p1;
    assign res_p2_d  = add_fn(prod_p1, addend_p1);
    assign acc_d     = res_p2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            acc_q    <= ACC_INIT;
        end else begin
            run_q    <= 1'b1;
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            if (ld_p2) begin
                acc_q <= acc_d;
            end
        end
    end

    // ---- input -> S0 boundary ----
    always_ff @(posedge clk) begin
        if (ld_p0) begin
            data_p0_q <= data_p0_d;
        end
    end

    // ---- S0 -> S1 boundary ----
    mul_add_mul_stage #(
        .WIDTH (WIDTH)
    ) u_mul_stage (
        .clk_i         (clk),
        .ld_p1_i       (ld_p1),
        .data_p0_i     (data_p0_q),
        .prod_p1_o     (prod_p1),
        .z_p1_o        (z_p1),
        .acc_mode_p1_o (acc_mode_p1)
    );

    // ---- S1 -> S2 boundary ----
    always_ff @(posedge clk) begin
        if (ld_p2) begin
            res_p2_q <= res_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out       = vld_p2_q ? res_p2_q : '0;

endmodule

// File: tb/tb_mul_add_pipe.sv
// Directed testbench for mul_add_pipe (WIDTH=32, ACC_INIT=100), with a short
// randomized handshake run against a reference model. Expected values follow
// MUL_ADD_PIPE_SAT_EN when it is defined for the build.
module tb_mul_add_pipe;
    import mul_add_pkg::*;

    localparam int          W     = 32;
    localparam logic [31:0] AINIT = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [31:0] z = '0;
    logic        acc_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          n;
    logic [31:0] got[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_acc;
    logic [31:0] r;
    logic [31:0] exp_acc4[5];
    logic [31:0] exp_stall[3];
    logic [31:0] exp_sat[4];

    mul_add_pipe #(
        .WIDTH    (W),
        .ACC_INIT (AINIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output transfers happen at the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got.push_back(out);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
`ifdef MUL_ADD_PIPE_SAT_EN
        if (full > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return full[31:0];
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
`ifdef MUL_ADD_PIPE_SAT_EN
        if (s[32]) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int cnt);
        for (int k = 0; k < 400 && got.size() < cnt; k++) tick();
    endtask

    initial begin
        exp_acc4  = '{32'd0, 32'd2, 32'd6, 32'd12, 32'd20};
        exp_stall = '{32'd20, 32'd23, 32'd26};
`ifdef MUL_ADD_PIPE_SAT_EN
        exp_sat   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
        exp_sat   = '{32'd1, 32'd0, 32'd5, 32'd6};
`endif

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Single item latency: 3*5+7 = 22 exactly STAGES cycles after transfer
        x = 3; y = 5; z = 7; acc_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lat_valid_c%0d", k), 32'(out_valid), (k == STAGES) ? 32'd1 : 32'd0);
            if (k == STAGES) chk("lat_out", out, 22);
            if (k == 1) chk("idle_out_zero", out, 0);
            tick();
        end

        // acc cleared by a z-mode item, then four back-to-back accumulate items
        got.delete(); got_cyc.delete();
        x = 0; y = 0; z = 0; acc_mode = 1'b0; in_valid = 1'b1;
        tick();
        acc_mode = 1'b1; y = 2; z = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            x = 32'(i);
            tick();
        end
        in_valid = 1'b0; acc_mode = 1'b0;
        wait_got(5);
        chk("acc_count", 32'(got.size()), 5);
        if (got.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("acc_out%0d", i), got[i], exp_acc4[i]);
            chk("acc_consecutive", 32'(got_cyc[4] - got_cyc[0]), 4);
        end

        // Backpressure: out_ready low for 10 cycles, items x=10+n, y=2, z=n
        got.delete(); got_cyc.delete();
        out_ready = 1'b0; in_valid = 1'b1; acc_mode = 1'b0; y = 2;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            x = 32'(10 + n); z = 32'(n);
            #1;
            if (in_ready) n++;
            tick();
        end
        chk("stall_accepted", 32'(n), 3);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_out_held", out, 20);
        chk("stall_no_output", 32'(got.size()), 0);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_got(3);
        chk("stall_count", 32'(got.size()), 3);
        if (got.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("stall_out%0d", i), got[i], exp_stall[i]);
        end

        // Overflow: product wrap/saturate, sum wrap/saturate, acc after saturation
        got.delete(); got_cyc.delete();
        in_valid = 1'b1; acc_mode = 1'b0;
        x = 32'hFFFF_FFFF; y = 2; z = 3;            tick();
        x = 1; y = 1; z = 32'hFFFF_FFFF;            tick();
        x = 32'h0001_0000; y = 32'h0001_0000; z = 5; tick();
        acc_mode = 1'b1; x = 1; y = 1; z = 0;       tick();
        in_valid = 1'b0; acc_mode = 1'b0;
        wait_got(4);
        chk("ovf_count", 32'(got.size()), 4);
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("ovf_out%0d", i), got[i], exp_sat[i]);
        end

        // Reset with three items in flight
        in_valid = 1'b1; acc_mode = 1'b0; x = 2; y = 3; z = 4;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("flight_out_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_out", out, 0);
        got.delete(); got_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rerst_in_ready", 32'(in_ready), 1);
        acc_mode = 1'b1; x = 1; y = 1; z = 0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; acc_mode = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("rerst_count", 32'(got.size()), 1);
        if (got.size() == 1) chk("rerst_acc_init", got[0], AINIT + 32'd1);

        // Random handshakes against the reference model
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got.delete(); got_cyc.delete(); exp_q.delete();
        m_acc = AINIT;
        n = 0;
        for (int k = 0; k < 6000 && n < 500; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 65535);
            y = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 65535);
            z = $urandom;
            acc_mode = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                r = ref_add(ref_mul(x, y), acc_mode ? m_acc : z);
                m_acc = r;
                exp_q.push_back(r);
                n++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_got(n);
        chk("rand_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("rand_%0d", i), got[i], exp_q[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_add_pipe.md
MUL_ADD_PIPE -- requirements
Module: mul_add_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand, addend and result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter ACC_INIT, default 0: value loaded into the accumulator at reset.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: x/y/z/acc_mode are valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts input this cycle.
REQ-007 Port x, input, WIDTH: unsigned multiplicand.
REQ-008 Port y, input, WIDTH: unsigned multiplier.
REQ-009 Port z, input, WIDTH: unsigned addend, used when acc_mode=0.
REQ-010 Port acc_mode, input, 1: 1 = add product to accumulator instead of z.
REQ-011 Port out_valid, output, 1: out holds a result.
REQ-012 Port out_ready, input, 1: downstream accepts out this cycle.
REQ-013 Port out, output, WIDTH: result.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer on out_valid && out_ready.
REQ-015 The datapath SHALL have three registered stages: S0 (captured x, y, z, acc_mode), S1 (product, z, acc_mode), S2 (result); each stage has a valid bit.
REQ-016 With out_ready held 1, out_valid SHALL rise exactly 3 cycles after the input transfer, with one result per cycle at full throughput.
REQ-017 A stage SHALL load when it is empty or its contents move on the same cycle; in_ready = !S0_valid || S0 advances (combinational from out_ready, no bubble).
REQ-018 When out_ready=0 and all stages are full, in_ready SHALL be 0 and no stage register SHALL change.
REQ-019 The S1 product SHALL equal (x*y) mod 2^WIDTH.
REQ-020 The S2 result SHALL equal (product + addend) mod 2^WIDTH, where addend = acc_mode ? acc : z.
REQ-021 The accumulator acc SHALL take the value written into S2 on every S2 load, including loads with acc_mode=0.
REQ-022 Back-to-back acc_mode items SHALL each see the result of the immediately preceding item, because acc is read at the S1->S2 transfer; no stall or forwarding is required.
REQ-023 Results SHALL leave in input order; none SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-024 On rst_n=0, all stage valid bits SHALL clear and acc SHALL load ACC_INIT, asynchronously; out_valid=0 immediately.
REQ-025 While rst_n=0, in_ready SHALL be 0; data registers need no reset value, and out SHALL be 0 while out_valid=0.
REQ-026 Reset mid-operation SHALL discard all in-flight items; the first input after release is processed normally.

Configuration
REQ-027 With macro MUL_ADD_PIPE_SAT_EN defined, the product SHALL saturate to 2^WIDTH-1 when x*y >= 2^WIDTH, and the sum SHALL saturate to 2^WIDTH-1 on carry-out; acc stores the saturated value.
REQ-028 Without MUL_ADD_PIPE_SAT_EN, REQ-019/REQ-020 modulo wrap SHALL apply and no full-width product is kept.

Structure
REQ-029 Package mul_add_pkg SHALL hold the stage-0 struct typedef (x, y, z, acc_mode) and the stage-count constant 3.
REQ-030 The product stage SHALL be a sub-module mul_add_mul_stage (S0->S1 register plus multiply/saturate); the handshake and accumulator stay in the top.

Verification
REQ-031 WIDTH=32, out_ready=1; x=3, y=5, z=7 at cycle 0 -> out=22, out_valid=1 at cycle 3 only.
REQ-032 Four items (acc_mode=1, x=i, y=2, i=1..4) back-to-back, ACC_INIT=0 -> outputs 2, 6, 12, 20 on consecutive cycles.
REQ-033 out_ready=0 for 10 cycles with in_valid=1 -> exactly 3 accepted, in_ready=0 thereafter; after release all items emerge in order with no loss.
REQ-034 x=0xFFFF_FFFF, y=2, z=3 -> out=0x0000_0001 without the macro; 0xFFFF_FFFF with MUL_ADD_PIPE_SAT_EN.
REQ-035 rst_n pulsed low with 3 items in flight -> out_valid=0 the same cycle, acc=ACC_INIT, next acc_mode item x=1, y=1 -> out=ACC_INIT+1.
REQ-036 Random in_valid/out_ready at 50% over 10k items -> scoreboard matches the reference model for both macro settings.
